alu_mc: RTL and testbench

Multi-cycle, parametrised successor to the execute-stage ALU. It accepts one operation at a time from the EX stage through a valid/busy handshake and registers every result. Single-cycle ops and branch resolution finish in one cycle; pipelined multiply and iterative unsigned divide take several cycles and stall the front end. It adds signed compares, arithmetic shift, MULH and DIVU/REMU. Branch resolution still drives the predictor-flush decision. The flush now also fires when the predicted target differs from the true target.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/div_iter.sv | 64 ++++++
 rtl/alu_mc.sv | 190 +++++++++++++++++++
 tb/tb_alu_mc.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the multi-cycle execute ALU.
//   - OP_W / OP_*   : operation code width and encodings
//   - ST_W / ST_*   : controller state encoding
package alu_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] OP_ADD  = 5'h00;
  localparam logic [OP_W-1:0] OP_SUB  = 5'h01;
  localparam logic [OP_W-1:0] OP_AND  = 5'h02;
  localparam logic [OP_W-1:0] OP_OR   = 5'h03;
  localparam logic [OP_W-1:0] OP_XOR  = 5'h04;
  localparam logic [OP_W-1:0] OP_NOT  = 5'h05;
  localparam logic [OP_W-1:0] OP_SLL  = 5'h06;
  localparam logic [OP_W-1:0] OP_SRL  = 5'h07;
  localparam logic [OP_W-1:0] OP_EQ   = 5'h08;
  localparam logic [OP_W-1:0] OP_LTU  = 5'h09;
  localparam logic [OP_W-1:0] OP_GTU  = 5'h0A;
  localparam logic [OP_W-1:0] OP_MUL  = 5'h0B;
  localparam logic [OP_W-1:0] OP_SRA  = 5'h0C;
  localparam logic [OP_W-1:0] OP_LT   = 5'h0D;
  localparam logic [OP_W-1:0] OP_GT   = 5'h0E;
  localparam logic [OP_W-1:0] OP_MULH = 5'h0F;
  localparam logic [OP_W-1:0] OP_DIVU = 5'h10;
  localparam logic [OP_W-1:0] OP_REMU = 5'h11;

  localparam int ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_MUL  = 2'd1;
  localparam logic [ST_W-1:0] ST_DIV  = 2'd2;

endpackage

// File: rtl/div_iter.sv
// div_iter: restoring unsigned divider, one quotient bit per cycle.
//   clk, rst            : clock, asynchronous active-high reset
//   start               : load dividend/divisor and begin XLEN iterations
//   abort               : drop the operation in progress
//   dividend, divisor   : operands, sampled on start
//   quotient, remainder : results, meaningful in the cycle done is high
//   done                : high during the last iteration cycle
module div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            done
);

  localparam int CW = $clog2(XLEN + 1);

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvs;
  logic [XLEN:0]   r_sh;
  logic [XLEN:0]   diff;
  logic            fit;

  // Outputs are the result of the current iteration, so the final values are
  // available combinationally during the last iteration cycle and the caller
  // can register them without an extra cycle.
  always_comb begin
    r_sh      = {rem, quo[XLEN-1]};
    diff      = r_sh - {1'b0, dvs};
    fit       = ~diff[XLEN];
    quotient  = {quo[XLEN-2:0], fit};
    remainder = fit ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
    done      = (cnt == CW'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      quo <= '0;
      rem <= '0;
      dvs <= '0;
    end else if (abort) begin
      cnt <= '0;
    end else if (start) begin
      quo <= dividend;
      rem <= '0;
      dvs <= divisor;
      cnt <= CW'(XLEN);
    end else if (cnt != '0) begin
      quo <= quotient;
      rem <= remainder;
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execute-stage ALU with branch resolution.
//   clk, rst             : clock, asynchronous active-high reset
//   EX_valid / EX_busy   : offer / back-pressure handshake
//   EX_flush             : kill any in-flight op
//   EX_a, EX_b           : operands, or branch PC and offset
//   EX_a2, EX_b2         : branch compare operands
//   EX_alu_op            : operation code (alu_pkg::OP_*)
//   EX_brn, EX_jmp       : branch / unconditional jump
//   EX_BP_taken, EX_BP_target_pc : predictor decision
//   EX_out_valid         : one-cycle result pulse
//   EX_alu_out           : result or resolved next PC
//   EX_taken             : mispredict (flush request)
//   EX_true_taken        : actual branch direction
module alu_mc
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int PC_BITS    = 12,
  parameter int MUL_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               EX_valid,
  input  logic               EX_flush,
  input  logic [XLEN-1:0]    EX_a,
  input  logic [XLEN-1:0]    EX_b,
  input  logic [XLEN-1:0]    EX_a2,
  input  logic [XLEN-1:0]    EX_b2,
  input  logic [OP_W-1:0]    EX_alu_op,
  input  logic               EX_brn,
  input  logic               EX_jmp,
  input  logic               EX_BP_taken,
  input  logic [PC_BITS-1:0] EX_BP_target_pc,
  output logic               EX_busy,
  output logic               EX_out_valid,
  output logic [XLEN-1:0]    EX_alu_out,
  output logic               EX_taken,
  output logic               EX_true_taken
);

  localparam int SH = $clog2(XLEN);
  // Intermediate multiply stages; the output register is the final stage.
  localparam int PD = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;

  logic [ST_W-1:0]   state;
  logic              accept;
  logic [2*XLEN-1:0] prod;
  logic [SH-1:0]     shamt;
  logic [XLEN-1:0]   alu_res;
  logic [XLEN-1:0]   next_pc;
  logic              cmp_res;
  logic              br_true;
  logic              br_mis;
  logic              is_mul;
  logic              is_div;
  logic              rem_sel;

  logic [XLEN-1:0]   mul_p [PD];
  logic [PD-1:0]     mul_v;

  logic [XLEN-1:0]   div_q;
  logic [XLEN-1:0]   div_r;
  logic              div_done;

  assign EX_busy = (state != ST_IDLE);
  assign accept  = EX_valid & ~EX_busy & ~EX_flush;

  always_comb begin
    prod  = {{XLEN{1'b0}}, EX_a} * {{XLEN{1'b0}}, EX_b};
    shamt = EX_b[SH-1:0];

    cmp_res = 1'b1;
    case (EX_alu_op)
      OP_EQ:   cmp_res = (EX_a2 == EX_b2);
      OP_LTU:  cmp_res = (EX_a2 <  EX_b2);
      OP_GTU:  cmp_res = (EX_a2 >  EX_b2);
      OP_LT:   cmp_res = ($signed(EX_a2) < $signed(EX_b2));
      OP_GT:   cmp_res = ($signed(EX_a2) > $signed(EX_b2));
      default: cmp_res = 1'b1;
    endcase
    br_true = EX_jmp | cmp_res;
    next_pc = br_true ? (EX_a + EX_b) : (EX_a + XLEN'(1));
    br_mis  = (EX_BP_taken != br_true) |
              (br_true & (EX_BP_target_pc != next_pc[PC_BITS-1:0]));

    // DIVU/REMU entries give the divide-by-zero result; real divides
    // take the iterative path instead.
    case (EX_alu_op)
      OP_SUB:  alu_res = EX_a - EX_b;
      OP_AND:  alu_res = EX_a & EX_b;
      OP_OR:   alu_res = EX_a | EX_b;
      OP_XOR:  alu_res = EX_a ^ EX_b;
      OP_NOT:  alu_res = ~EX_a;
      OP_SLL:  alu_res = EX_a << shamt;
      OP_SRL:  alu_res = EX_a >> shamt;
      OP_EQ:   alu_res = {{(XLEN-1){1'b0}}, EX_a == EX_b};
      OP_LTU:  alu_res = {{(XLEN-1){1'b0}}, EX_a <  EX_b};
      OP_GTU:  alu_res = {{(XLEN-1){1'b0}}, EX_a >  EX_b};
      OP_MUL:  alu_res = prod[XLEN-1:0];
      OP_SRA:  alu_res = $unsigned($signed(EX_a) >>> shamt);
      OP_LT:   alu_res = {{(XLEN-1){1'b0}}, $signed(EX_a) < $signed(EX_b)};
      OP_GT:   alu_res = {{(XLEN-1){1'b0}}, $signed(EX_a) > $signed(EX_b)};
      OP_MULH: alu_res = prod[2*XLEN-1:XLEN];
      OP_DIVU: alu_res = '1;
      OP_REMU: alu_res = EX_a;
      default: alu_res = EX_a + EX_b;
    endcase

    is_mul = ~EX_brn & ((EX_alu_op == OP_MUL) | (EX_alu_op == OP_MULH));
    is_div = ~EX_brn & ((EX_alu_op == OP_DIVU) | (EX_alu_op == OP_REMU)) &
             (EX_b != '0);
  end

  div_iter #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (accept & is_div),
    .abort     (EX_flush),
    .dividend  (EX_a),
    .divisor   (EX_b),
    .quotient  (div_q),
    .remainder (div_r),
    .done      (div_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      EX_out_valid  <= 1'b0;
      EX_alu_out    <= '0;
      EX_taken      <= 1'b0;
      EX_true_taken <= 1'b0;
      rem_sel       <= 1'b0;
      mul_v         <= '0;
      for (int unsigned i = 0; i < PD; i++) mul_p[i] <= '0;
    end else begin
      EX_out_valid <= 1'b0;
      for (int unsigned i = 1; i < PD; i++) begin
        mul_p[i] <= mul_p[i-1];
        mul_v[i] <= mul_v[i-1];
      end
      mul_v[0] <= 1'b0;

      if (EX_flush) begin
        state <= ST_IDLE;
        mul_v <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              if (is_mul && (MUL_STAGES > 1)) begin
                mul_p[0] <= alu_res;
                mul_v[0] <= 1'b1;
                state    <= ST_MUL;
              end else if (is_div) begin
                rem_sel <= (EX_alu_op == OP_REMU);
                state   <= ST_DIV;
              end else begin
                EX_out_valid  <= 1'b1;
                EX_alu_out    <= EX_brn ? next_pc : alu_res;
                EX_taken      <= EX_brn & br_mis;
                EX_true_taken <= EX_brn & br_true;
              end
            end
          end
          ST_MUL: begin
            if (mul_v[PD-1]) begin
              state         <= ST_IDLE;
              EX_out_valid  <= 1'b1;
              EX_alu_out    <= mul_p[PD-1];
              EX_taken      <= 1'b0;
              EX_true_taken <= 1'b0;
            end
          end
          ST_DIV: begin
            if (div_done) begin
              state         <= ST_IDLE;
              EX_out_valid  <= 1'b1;
              EX_alu_out    <= rem_sel ? div_r : div_q;
              EX_taken      <= 1'b0;
              EX_true_taken <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        EX_valid;
  logic        EX_flush;
  logic [31:0] EX_a, EX_b, EX_a2, EX_b2;
  logic [4:0]  EX_alu_op;
  logic        EX_brn, EX_jmp, EX_BP_taken;
  logic [11:0] EX_BP_target_pc;
  logic        EX_busy, EX_out_valid, EX_taken, EX_true_taken;
  logic [31:0] EX_alu_out;

  int checks = 0;
  int errors = 0;
  int lat;
  int pulses;

  always #5 clk = ~clk;

  alu_mc #(.XLEN(32), .PC_BITS(12), .MUL_STAGES(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .EX_valid        (EX_valid),
    .EX_flush        (EX_flush),
    .EX_a            (EX_a),
    .EX_b            (EX_b),
    .EX_a2           (EX_a2),
    .EX_b2           (EX_b2),
    .EX_alu_op       (EX_alu_op),
    .EX_brn          (EX_brn),
    .EX_jmp          (EX_jmp),
    .EX_BP_taken     (EX_BP_taken),
    .EX_BP_target_pc (EX_BP_target_pc),
    .EX_busy         (EX_busy),
    .EX_out_valid    (EX_out_valid),
    .EX_alu_out      (EX_alu_out),
    .EX_taken        (EX_taken),
    .EX_true_taken   (EX_true_taken)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  // Present an operation; the caller is at a negedge.
  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic brn = 1'b0, input logic jmp = 1'b0,
                       input logic [31:0] a2 = 32'd0, input logic [31:0] b2 = 32'd0,
                       input logic bpt = 1'b0, input logic [11:0] tgt = 12'd0);
    EX_valid = 1'b1; EX_alu_op = op; EX_a = a; EX_b = b; EX_brn = brn; EX_jmp = jmp;
    EX_a2 = a2; EX_b2 = b2; EX_BP_taken = bpt; EX_BP_target_pc = tgt;
  endtask

  // Offer for one cycle; returns in the cycle after the accept edge.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic brn = 1'b0, input logic jmp = 1'b0,
                       input logic [31:0] a2 = 32'd0, input logic [31:0] b2 = 32'd0,
                       input logic bpt = 1'b0, input logic [11:0] tgt = 12'd0);
    drive(op, a, b, brn, jmp, a2, b2, bpt, tgt);
    step;
    EX_valid = 1'b0;
  endtask

  // lat = cycles from accept to the out_valid pulse (40 = never seen).
  task automatic wait_ov(output int l);
    l = 1;
    while (!EX_out_valid && l < 40) begin
      step;
      l++;
    end
  endtask

  initial begin
    rst = 1'b1; EX_valid = 1'b0; EX_flush = 1'b0;
    EX_a = '0; EX_b = '0; EX_a2 = '0; EX_b2 = '0; EX_alu_op = '0;
    EX_brn = 1'b0; EX_jmp = 1'b0; EX_BP_taken = 1'b0; EX_BP_target_pc = '0;
    step; step;
    chk("rst_busy", EX_busy, 0);
    chk("rst_ov", EX_out_valid, 0);
    chk("rst_out", EX_alu_out, 0);
    chk("rst_taken", EX_taken, 0);
    chk("rst_true", EX_true_taken, 0);
    rst = 1'b0;
    step;

    // Back-to-back single-cycle ops
    drive(OP_ADD, 32'd3, 32'd4);
    step;
    chk("b2b_add_ov", EX_out_valid, 1);
    chk("b2b_add", EX_alu_out, 32'd7);
    drive(OP_SUB, 32'd3, 32'd5);
    step;
    EX_valid = 1'b0;
    chk("b2b_sub_ov", EX_out_valid, 1);
    chk("b2b_sub", EX_alu_out, 32'hFFFF_FFFE);
    step;
    chk("hold_ov", EX_out_valid, 0);
    chk("hold_out", EX_alu_out, 32'hFFFF_FFFE);

    issue(OP_SRA, 32'h8000_0000, 32'd36);
    chk("sra", EX_alu_out, 32'hF800_0000);
    issue(OP_SRL, 32'h8000_0000, 32'd4);
    chk("srl", EX_alu_out, 32'h0800_0000);
    issue(OP_NOT, 32'h0000_0000, 32'd9);
    chk("not", EX_alu_out, 32'hFFFF_FFFF);
    issue(OP_LT, 32'hFFFF_FFFF, 32'd1);
    chk("lt", EX_alu_out, 32'd1);
    issue(OP_GT, 32'hFFFF_FFFF, 32'd1);
    chk("gt", EX_alu_out, 32'd0);
    issue(OP_LTU, 32'hFFFF_FFFF, 32'd1);
    chk("ltu", EX_alu_out, 32'd0);
    issue(5'h1F, 32'd10, 32'd20);
    chk("undef_add", EX_alu_out, 32'd30);

    // Branches
    issue(OP_EQ, 32'd100, 32'd20, 1'b1, 1'b0, 32'd5, 32'd5, 1'b1, 12'd120);
    chk("beq_ov", EX_out_valid, 1);
    chk("beq_out", EX_alu_out, 32'd120);
    chk("beq_true", EX_true_taken, 1);
    chk("beq_taken", EX_taken, 0);
    issue(OP_EQ, 32'd100, 32'd20, 1'b1, 1'b0, 32'd5, 32'd5, 1'b1, 12'd121);
    chk("beq_tgt_taken", EX_taken, 1);
    issue(OP_LT, 32'd100, 32'd20, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 12'd0);
    chk("blt_true", EX_true_taken, 1);
    chk("blt_taken", EX_taken, 1);
    issue(OP_LTU, 32'd100, 32'd20, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 12'd0);
    chk("bltu_true", EX_true_taken, 0);
    chk("bltu_taken", EX_taken, 0);
    chk("bltu_out", EX_alu_out, 32'd101);
    issue(OP_EQ, 32'd100, 32'd20, 1'b1, 1'b1, 32'd1, 32'd2, 1'b1, 12'd120);
    chk("jmp_true", EX_true_taken, 1);
    chk("jmp_taken", EX_taken, 0);
    issue(OP_MUL, 32'd200, 32'd8, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 12'd0);
    chk("brn_mulop_busy", EX_busy, 0);
    chk("brn_mulop_ov", EX_out_valid, 1);
    chk("brn_mulop_out", EX_alu_out, 32'd208);
    chk("brn_mulop_taken", EX_taken, 1);
    issue(OP_ADD, 32'd1, 32'd1);
    chk("nonbr_true", EX_true_taken, 0);
    chk("nonbr_taken", EX_taken, 0);

    // Multiply
    issue(OP_MULH, 32'hFFFF_FFFF, 32'd2);
    chk("mulh_busy", EX_busy, 1);
    chk("mulh_ov_early", EX_out_valid, 0);
    step;
    chk("mulh_ov", EX_out_valid, 1);
    chk("mulh_out", EX_alu_out, 32'd1);
    chk("mulh_busy_end", EX_busy, 0);
    issue(OP_MUL, 32'hFFFF_FFFF, 32'd2);
    step;
    chk("mul_out", EX_alu_out, 32'hFFFF_FFFE);

    // Divide
    issue(OP_DIVU, 32'd100, 32'd7);
    chk("divu_busy", EX_busy, 1);
    wait_ov(lat);
    chk("divu_lat", lat, 33);
    chk("divu_out", EX_alu_out, 32'd14);
    chk("divu_busy_end", EX_busy, 0);
    issue(OP_REMU, 32'd100, 32'd7);
    wait_ov(lat);
    chk("remu_lat", lat, 33);
    chk("remu_out", EX_alu_out, 32'd2);
    issue(OP_DIVU, 32'd55, 32'd0);
    chk("div0_ov", EX_out_valid, 1);
    chk("div0_busy", EX_busy, 0);
    chk("div0_out", EX_alu_out, 32'hFFFF_FFFF);
    issue(OP_REMU, 32'd55, 32'd0);
    chk("rem0_out", EX_alu_out, 32'd55);

    // Flush mid-divide, with an op offered in the flush cycle
    issue(OP_DIVU, 32'd100, 32'd7);
    step; step; step; step;
    EX_flush = 1'b1;
    drive(OP_ADD, 32'd9, 32'd9);
    step;
    EX_flush = 1'b0;
    EX_valid = 1'b0;
    chk("flush_busy", EX_busy, 0);
    chk("flush_ov", EX_out_valid, 0);
    pulses = 0;
    repeat (40) begin
      step;
      if (EX_out_valid) pulses++;
    end
    chk("flush_no_result", pulses, 0);
    issue(OP_ADD, 32'd1, 32'd2);
    chk("post_flush_ov", EX_out_valid, 1);
    chk("post_flush_out", EX_alu_out, 32'd3);

    // Flush while idle blocks an offered op
    EX_flush = 1'b1;
    issue(OP_ADD, 32'd5, 32'd5);
    EX_flush = 1'b0;
    chk("idle_flush_ov", EX_out_valid, 0);
    chk("idle_flush_out", EX_alu_out, 32'd3);

    // Reset mid-divide
    issue(OP_DIVU, 32'd100, 32'd7);
    step; step; step;
    rst = 1'b1;
    #1;
    chk("rstdiv_busy", EX_busy, 0);
    chk("rstdiv_ov", EX_out_valid, 0);
    chk("rstdiv_out", EX_alu_out, 0);
    chk("rstdiv_taken", EX_taken, 0);
    chk("rstdiv_true", EX_true_taken, 0);
    step;
    rst = 1'b0;
    step;
    issue(OP_ADD, 32'd3, 32'd4);
    chk("rstdiv_add_ov", EX_out_valid, 1);
    chk("rstdiv_add", EX_alu_out, 32'd7);
    pulses = 0;
    repeat (40) begin
      step;
      if (EX_out_valid) pulses++;
    end
    chk("rstdiv_no_late", pulses, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
